uart_txd_arbiter: RTL and testbench



---
 rtl/uart_txd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_txd_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txd_arbiter.sv
// Shares one UART TX pin among NUM_SRC transmitters; the first start bit owns the line until IDLE_BITS idle.
// Optional macro UART_TXD_ARBITER_LOOPBACK_EN adds loopback_en, routing synchronised RX back onto TX.
module uart_txd_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int IDLE_BITS   = 12,
    parameter int CNT_W       = 16,
    localparam int OWN_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               sys_clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_txd,
    input  logic               usb_uart_rxd,
`ifdef UART_TXD_ARBITER_LOOPBACK_EN
    input  logic               loopback_en,
`endif
    output logic               usb_uart_txd,
    output logic               usb_uart_rxd_debug,
    output logic               busy,
    output logic [OWN_W-1:0]   owner,
    output logic [CNT_W-1:0]   grant_cnt,
    output logic [CNT_W-1:0]   collision_cnt,
    output logic               collision
);

    localparam int BIT_TICKS  = CLK_FREQ_HZ / BAUD;
    localparam int IDLE_TICKS = IDLE_BITS * BIT_TICKS;
    localparam int IDLE_W     = $clog2(IDLE_TICKS + 1);
    localparam int SUM_W      = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    logic [NUM_SRC-1:0] r_src_meta, r_src_sync, r_src_prev;
    logic               r_rxd_meta, r_rxd_sync;
    state_t             r_state, w_state_nxt;
    logic [IDLE_W-1:0]  r_idle_cnt, w_idle_cnt_nxt;
    logic [OWN_W-1:0]   r_owner, w_owner_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_txd, w_arb_txd, w_txd_nxt;
    logic [CNT_W-1:0]   r_grant_cnt, w_grant_cnt_nxt;
    logic [CNT_W-1:0]   r_coll_cnt, w_coll_cnt_nxt;
    logic               r_collision;
    logic [NUM_SRC-1:0] w_fall, w_collide;
    logic               w_any_low, w_owner_bit;
    logic [OWN_W-1:0]   w_grant_idx;
    logic [SUM_W-1:0]   w_coll_sum;

    // Synchronisers idle high so reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_src_meta <= '1;
            r_src_sync <= '1;
            r_src_prev <= '1;
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_src_meta <= src_txd;
            r_src_sync <= r_src_meta;
            r_src_prev <= r_src_sync;
            r_rxd_meta <= usb_uart_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_fall = r_src_prev & ~r_src_sync;

    // Descending scan leaves the lowest low index as the grant candidate.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_any_low   = 1'b0;
        w_grant_idx = '0;
        w_owner_bit = 1'b1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!r_src_sync[i]) begin
                w_any_low   = 1'b1;
                w_grant_idx = OWN_W'(i);
            end
            if (r_owner == OWN_W'(i)) w_owner_bit = r_src_sync[i];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idle_cnt_nxt  = r_idle_cnt;
        w_owner_nxt     = r_owner;
        w_busy_nxt      = r_busy;
        w_grant_cnt_nxt = r_grant_cnt;
        w_arb_txd       = 1'b1;
        w_collide       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_low) begin
                    w_state_nxt    = ST_OWNED;
                    w_owner_nxt    = w_grant_idx;
                    w_busy_nxt     = 1'b1;
                    w_idle_cnt_nxt = '0;
                    w_arb_txd      = 1'b0;
                    if (r_grant_cnt != CNT_MAX) w_grant_cnt_nxt = r_grant_cnt + 1'b1;
                    for (int i = 0; i < NUM_SRC; i++)
                        if (OWN_W'(i) != w_grant_idx) w_collide[i] = w_fall[i];
                end
            end
            ST_OWNED: begin
                w_arb_txd = w_owner_bit;
                for (int i = 0; i < NUM_SRC; i++)
                    if (OWN_W'(i) != r_owner) w_collide[i] = w_fall[i];
                if (!w_owner_bit) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == IDLE_W'(IDLE_TICKS - 1)) begin
                    w_state_nxt    = ST_IDLE;
                    w_busy_nxt     = 1'b0;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
        endcase
    end

    // Simultaneous collisions each count; the sum clamps instead of wrapping.
    always_comb begin
        w_coll_sum = SUM_W'(r_coll_cnt);
        for (int i = 0; i < NUM_SRC; i++) w_coll_sum = w_coll_sum + SUM_W'(w_collide[i]);
        w_coll_cnt_nxt = (w_coll_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_coll_sum[CNT_W-1:0];
    end

`ifdef UART_TXD_ARBITER_LOOPBACK_EN
    assign w_txd_nxt = loopback_en ? r_rxd_sync : w_arb_txd;
`else
    assign w_txd_nxt = w_arb_txd;
`endif

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idle_cnt  <= '0;
            r_owner     <= '0;
            r_busy      <= 1'b0;
            r_txd       <= 1'b1;
            r_grant_cnt <= '0;
            r_coll_cnt  <= '0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_busy      <= w_busy_nxt;
            r_txd       <= w_txd_nxt;
            r_grant_cnt <= w_grant_cnt_nxt;
            r_coll_cnt  <= w_coll_cnt_nxt;
            r_collision <= |w_collide;
        end
    end

    assign usb_uart_txd       = r_txd;
    assign usb_uart_rxd_debug = r_rxd_sync;
    assign busy               = r_busy;
    assign owner              = r_owner;
    assign grant_cnt          = r_grant_cnt;
    assign collision_cnt      = r_coll_cnt;
    assign collision          = r_collision;

endmodule

// File: tb/tb_uart_txd_arbiter.sv
// Directed bench for uart_txd_arbiter: 3-source main instance (BIT_TICKS=100, IDLE_TICKS=1200)
// plus a 2-source CNT_W=2 instance (IDLE_TICKS=120) for counter saturation.
module tb_uart_txd_arbiter;

    logic        sys_clock = 1'b0;
    logic        reset, rst2;
    logic [2:0]  src_txd;
    logic [1:0]  s2_txd;
    logic        usb_uart_rxd;
    logic        usb_uart_txd, usb_uart_rxd_debug, busy, collision;
    logic [1:0]  owner;
    logic [15:0] grant_cnt, collision_cnt;
    logic        txd2, rxd_dbg2, busy2, collision2;
    logic [0:0]  owner2;
    logic [1:0]  grant2, coll2;
`ifdef UART_TXD_ARBITER_LOOPBACK_EN
    logic        loopback_en, loopback_en2;
`endif

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int pulses2 = 0;

    always #5 sys_clock = ~sys_clock;

    uart_txd_arbiter #(
        .NUM_SRC(3), .CLK_FREQ_HZ(100000000), .BAUD(1000000), .IDLE_BITS(12), .CNT_W(16)
    ) u_dut (
        .sys_clock(sys_clock), .reset(reset), .src_txd(src_txd), .usb_uart_rxd(usb_uart_rxd),
`ifdef UART_TXD_ARBITER_LOOPBACK_EN
        .loopback_en(loopback_en),
`endif
        .usb_uart_txd(usb_uart_txd), .usb_uart_rxd_debug(usb_uart_rxd_debug), .busy(busy),
        .owner(owner), .grant_cnt(grant_cnt), .collision_cnt(collision_cnt), .collision(collision)
    );

    uart_txd_arbiter #(
        .NUM_SRC(2), .CLK_FREQ_HZ(100000000), .BAUD(10000000), .IDLE_BITS(12), .CNT_W(2)
    ) u_sat (
        .sys_clock(sys_clock), .reset(rst2), .src_txd(s2_txd), .usb_uart_rxd(1'b1),
`ifdef UART_TXD_ARBITER_LOOPBACK_EN
        .loopback_en(loopback_en2),
`endif
        .usb_uart_txd(txd2), .usb_uart_rxd_debug(rxd_dbg2), .busy(busy2),
        .owner(owner2), .grant_cnt(grant2), .collision_cnt(coll2), .collision(collision2)
    );

    always @(negedge sys_clock) begin
        if (collision === 1'b1) pulses++;
        if (collision2 === 1'b1) pulses2++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus record: frames from the sources in mask, which source the pin must follow
    // (-1: pin stays high), and the status expected right after the stop bit.
    typedef struct {
        int          gap;
        logic [2:0]  mask;
        logic [7:0]  b0, b1, b2;
        int          fwd;
        int          rel;      // steps after the frame until busy drops (0: not checked)
        logic        e_busy;
        logic [1:0]  e_owner;
        logic [15:0] e_grant;
        logic [15:0] e_coll;
        int          e_pulses;
    } vec_t;

    vec_t vecs [4];

    // Each bit is held 100 cycles; the pin must still show the old bit 2 cycles after a
    // source change and the new bit exactly 3 cycles after it.
    task automatic send_vec(input vec_t v);
        logic [9:0] fr [3];
        logic       prev_pin, exp_pin;
        fr[0] = {1'b1, v.b0, 1'b0};
        fr[1] = {1'b1, v.b1, 1'b0};
        fr[2] = {1'b1, v.b2, 1'b0};
        prev_pin = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int s = 0; s < 3; s++) if (v.mask[s]) src_txd[s] = fr[s][k];
            if (v.fwd >= 0) exp_pin = fr[v.fwd][k];
            else            exp_pin = 1'b1;
            step(2);
            check("pin_before_edge", usb_uart_txd, prev_pin);
            step(1);
            check("pin_at_edge", usb_uart_txd, exp_pin);
            step(97);
            prev_pin = exp_pin;
        end
    endtask

    initial begin
        logic [9:0] rfr;
        logic       prev_pin;

        // 0x55 ends in a 0 bit, so the idle count starts at its stop bit: release 1102 steps on.
        vecs[0] = '{10,   3'b010, 8'h00, 8'h55, 8'h00,  1, 1102, 1'b1, 2'd1, 16'd1, 16'd0, 0};
        // Simultaneous starts: src 0 wins; 0xF0 from src 2 has no later falling edge.
        vecs[1] = '{10,   3'b101, 8'hA3, 8'h00, 8'hF0,  0,    0, 1'b1, 2'd0, 16'd2, 16'd1, 1};
        // Inside src 0's idle window: rejected, pin stays high; window closes during this frame.
        vecs[2] = '{500,  3'b100, 8'h00, 8'h00, 8'hF0, -1,    0, 1'b0, 2'd0, 16'd2, 16'd2, 2};
        // Line long idle: granted. 0xF0 is high from bit 4, so release is 702 steps on.
        vecs[3] = '{1300, 3'b100, 8'h00, 8'h00, 8'hF0,  2,  702, 1'b1, 2'd2, 16'd3, 16'd2, 2};

        reset = 1'b1;
        rst2 = 1'b1;
        src_txd = 3'b111;
        s2_txd = 2'b11;
        usb_uart_rxd = 1'b1;
`ifdef UART_TXD_ARBITER_LOOPBACK_EN
        loopback_en = 1'b0;
        loopback_en2 = 1'b0;
`endif
        step(2);
        check("rst_txd", usb_uart_txd, 1'b1);
        check("rst_rxd_debug", usb_uart_rxd_debug, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 2'd0);
        check("rst_grant", grant_cnt, 16'd0);
        check("rst_coll", collision_cnt, 16'd0);
        check("rst_collision", collision, 1'b0);
        step(1);
        reset = 1'b0;
        rst2 = 1'b0;

        for (int c = 0; c < 5; c++) begin
            step(1000);
            check("idle_txd", usb_uart_txd, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_grant", grant_cnt, 16'd0);
            check("idle_coll", collision_cnt, 16'd0);
        end

        usb_uart_rxd = 1'b0;
        step(1);
        check("rxd_debug_lat1", usb_uart_rxd_debug, 1'b1);
        step(1);
        check("rxd_debug_lat2", usb_uart_rxd_debug, 1'b0);
        usb_uart_rxd = 1'b1;
        step(2);
        check("rxd_debug_back", usb_uart_rxd_debug, 1'b1);

        for (int i = 0; i < 4; i++) begin
            step(vecs[i].gap);
            send_vec(vecs[i]);
            check("post_busy", busy, vecs[i].e_busy);
            check("post_owner", owner, vecs[i].e_owner);
            check("post_grant", grant_cnt, vecs[i].e_grant);
            check("post_coll", collision_cnt, vecs[i].e_coll);
            check("post_pulses", pulses, vecs[i].e_pulses);
            if (vecs[i].rel > 0) begin
                step(vecs[i].rel - 1);
                check("busy_before_release", busy, 1'b1);
                step(1);
                check("busy_released", busy, 1'b0);
                check("owner_held", owner, vecs[i].e_owner);
            end
        end

        // Reset in the middle of bit 4 of 0x0F from src 1; src 1 stays low across reset.
        step(20);
        src_txd[1] = 1'b0;
        step(100);
        src_txd[1] = 1'b1;
        step(400);
        src_txd[1] = 1'b0;
        step(50);
        check("mid_pin", usb_uart_txd, 1'b0);
        check("mid_owner", owner, 2'd1);
        check("mid_grant", grant_cnt, 16'd4);
        reset = 1'b1;
        #1;
        check("areset_txd", usb_uart_txd, 1'b1);
        check("areset_busy", busy, 1'b0);
        check("areset_owner", owner, 2'd0);
        check("areset_grant", grant_cnt, 16'd0);
        check("areset_coll", collision_cnt, 16'd0);
        check("areset_collision", collision, 1'b0);
        step(3);
        reset = 1'b0;
        step(2);
        check("regrant_wait_busy", busy, 1'b0);
        step(1);
        check("regrant_busy", busy, 1'b1);
        check("regrant_owner", owner, 2'd1);
        check("regrant_grant", grant_cnt, 16'd1);
        check("regrant_pin", usb_uart_txd, 1'b0);
        src_txd[1] = 1'b1;
        step(20);

`ifdef UART_TXD_ARBITER_LOOPBACK_EN
        loopback_en = 1'b1;
        step(5);
        rfr = {1'b1, 8'h7E, 1'b0};
        prev_pin = 1'b1;
        for (int k = 0; k < 10; k++) begin
            usb_uart_rxd = rfr[k];
            step(2);
            check("loop_before_edge", usb_uart_txd, prev_pin);
            step(1);
            check("loop_at_edge", usb_uart_txd, rfr[k]);
            step(97);
            prev_pin = rfr[k];
        end
        loopback_en = 1'b0;
        step(5);
`else
        rfr = '0;
        prev_pin = 1'b0;
`endif

        // Saturation: src 0 owns the line, src 1 pulses five start bits.
        s2_txd[0] = 1'b0;
        step(3);
        check("sat_grant", grant2, 2'd1);
        check("sat_busy", busy2, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            s2_txd[1] = 1'b0;
            step(4);
            s2_txd[1] = 1'b1;
            step(4);
            check("sat_coll", coll2, (k < 3) ? k : 3);
        end
        check("sat_pulses", pulses2, 5);
        check("sat_owner", owner2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
